lp_frame_tx: RTL
================

LP_FRAME_TX -- requirements
Module: lp_frame_tx

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 24'hFFFFFF, maximum WAIT-state cycles without a solver answer.
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 wr_en  input  1  row-buffer write strobe.
REQ-005 wr_addr  input  3  row index: 0 = objective (c1,c2); 1..6 = constraint rows.
REQ-006 wr_a1, wr_a2  input  6 each  signed coefficients to store.
REQ-007 wr_b  input  12  signed bound to store; ignored for row 0.
REQ-008 start  input  1  request to transmit one frame.
REQ-009 lp_valid  output  1  frame-valid strobe to the solver.
REQ-010 lp_a1, lp_a2  output  6 each  signed coefficients driven to the solver.
REQ-011 lp_b  output  12  signed bound driven to the solver.
REQ-012 lp_out_valid  input  1  solver result strobe.
REQ-013 lp_out_max_value  input  12  signed solver result.
REQ-014 busy  output  1  high from accepted start until done.
REQ-015 done  output  1  one-cycle completion pulse.
REQ-016 result  output  12  signed captured result, held until the next accepted start.
REQ-017 timeout  output  1  qualifies done; 1 = no solver answer.

Function
REQ-018 FSM states SHALL be IDLE, SEND, WAIT, DONE; reset state IDLE.
REQ-019 Row buffer SHALL be 7 entries x 24 bits; a write SHALL commit only when wr_en=1, state=IDLE, start=0, and wr_addr<=6.
- wr_addr=7 dropped.
- Write coincident with start dropped.
- Writes in SEND/WAIT/DONE dropped.
REQ-020 start SHALL be accepted only in IDLE; start elsewhere ignored, not queued.
REQ-021 Start accepted at edge T: busy=1 from T+1; state SEND for 7 cycles.
REQ-022 lp_valid SHALL be high for exactly 7 contiguous cycles, T+1..T+7, with all lp_* outputs registered.
REQ-023 Beat k (cycle T+1+k) SHALL drive row k.
- Beat 0: c1 on lp_a1, c2 on lp_a2, lp_b=0.
REQ-024 Beat index SHALL be a 3-bit counter 0..6; SEND→WAIT when index=6; no wrap to 7.
REQ-025 lp_valid SHALL be 0 at T+8, and lp_a1/lp_a2/lp_b SHALL return to 0 whenever lp_valid=0.
REQ-026 In WAIT, lp_out_valid=1 SHALL capture lp_out_max_value into result and set timeout=0; next state DONE.
REQ-027 The WAIT cycle counter SHALL be 24 bits, cleared on WAIT entry and incremented each WAIT cycle.
REQ-028 When the WAIT counter reaches TIMEOUT_CYCLES-1 with lp_out_valid=0, the block SHALL set result=12'h800 (-2048) and timeout=1, then go to DONE.
REQ-029 lp_out_valid in the same cycle as timeout expiry SHALL win (timeout=0, value captured).
REQ-030 DONE SHALL last one cycle with done=1, then go to IDLE; busy SHALL be 0 in the DONE cycle.
REQ-031 lp_out_valid in IDLE/SEND/DONE SHALL be ignored, with no effect on result.
REQ-032 Minimum gap between frames SHALL be 2 cycles of lp_valid=0: DONE→IDLE, then a start accepted in IDLE.
REQ-033 Row buffer contents SHALL persist across frames; resending needs only start.

Reset
REQ-034 rst_n low at any time SHALL immediately force:
- state IDLE;
- lp_valid, lp_a1, lp_a2, lp_b, busy, done, result, timeout all 0;
- counters 0;
- all buffer rows 0.
REQ-035 Reset mid-SEND SHALL truncate the frame (lp_valid low asynchronously); no resumption after release.
REQ-036 The first start after reset release SHALL be accepted only on a rising edge where rst_n=1.

Verification
REQ-037 Load row0=(3,2), rows 1..6 = (1,0,10), (-1,0,0), (0,1,8), (0,-1,0), (1,1,12), (2,1,20); start → 7 lp_valid beats in that order, beat0 lp_b=0.
REQ-038 After the REQ-037 frame, drive lp_out_valid with 32 in WAIT → next cycle done=1, result=32, timeout=0, busy=0.
REQ-039 TIMEOUT_CYCLES=16 and no answer → done at WAIT cycle 16, timeout=1, result=-2048 (12'h800).
REQ-040 Boundary writes:
- wr_addr=7 → no buffer change.
- Write during SEND → no buffer change.
- Write with start → dropped.
- start while busy → no second frame.
REQ-041 lp_out_valid and timeout expiry in the same cycle → timeout=0, value captured.
- Separately: rst_n low at beat 3 → all outputs 0 at once; new start after release sends a full 7-beat frame.

Source files
------------

// File: rtl/lp_frame_tx_if.sv
// Solver-side bus of lp_frame_tx.
//   master : the frame transmitter; drives lp_valid/lp_a1/lp_a2/lp_b and
//            receives the solver's lp_out_valid/lp_out_max_value answer.
//   slave  : the LP solver side of the same bus.
interface lp_frame_tx_if;
    logic        lp_valid;          // frame beat valid
    logic [5:0]  lp_a1;             // signed coefficient 1
    logic [5:0]  lp_a2;             // signed coefficient 2
    logic [11:0] lp_b;              // signed bound
    logic        lp_out_valid;      // solver result strobe
    logic [11:0] lp_out_max_value;  // signed solver result

    modport master (
        output lp_valid, lp_a1, lp_a2, lp_b,
        input  lp_out_valid, lp_out_max_value
    );

    modport slave (
        input  lp_valid, lp_a1, lp_a2, lp_b,
        output lp_out_valid, lp_out_max_value
    );
endinterface

// File: rtl/lp_frame_tx.sv
// Transmits a stored 7-row LP problem (objective row + 6 constraint rows) to a
// solver as a 7-beat frame, then waits for the solver answer or a timeout.
//   clk, rst_n        : clock, asynchronous active-low reset
//   wr_en, wr_addr    : row buffer write (row 0 = objective, 1..6 = constraints)
//   wr_a1, wr_a2, wr_b: signed row contents (wr_b ignored for row 0)
//   start             : request one frame (accepted only when idle)
//   lp                : solver bus (lp_frame_tx_if.master)
//   busy              : frame in progress (SEND and WAIT)
//   done              : one-cycle completion pulse
//   result, timeout   : captured answer; timeout=1 means no answer (result -2048)
module lp_frame_tx #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'hFFFFFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [2:0]        wr_addr,
    input  logic [5:0]        wr_a1,
    input  logic [5:0]        wr_a2,
    input  logic [11:0]       wr_b,
    input  logic              start,
    lp_frame_tx_if.master     lp,
    output logic              busy,
    output logic              done,
    output logic [11:0]       result,
    output logic              timeout
);

    typedef enum logic [1:0] {StIdle, StSend, StWait, StDone} state_e;

    localparam logic [2:0]  LastBeat = 3'd6;
    localparam logic [23:0] WaitLast = TIMEOUT_CYCLES - 24'd1;

    state_e      state_q, state_d;
    logic [2:0]  beat_q, beat_d;
    logic [23:0] wait_cnt_q, wait_cnt_d;
    logic        lp_valid_q, lp_valid_d;
    logic [5:0]  lp_a1_q, lp_a1_d;
    logic [5:0]  lp_a2_q, lp_a2_d;
    logic [11:0] lp_b_q, lp_b_d;
    logic [11:0] result_q, result_d;
    logic        timeout_q, timeout_d;

    // Row layout: {a1, a2, b}
    logic [23:0] rows_q [7];
    logic        row_we;
    logic [23:0] row_wdata;
    logic [2:0]  next_beat;

    // Writes only land while idle and not racing a start; address 7 has no row.
    assign row_we    = wr_en && (state_q == StIdle) && !start && (wr_addr != 3'd7);
    // The objective row carries no bound, so store a zero bound for beat 0.
    assign row_wdata = (wr_addr == 3'd0) ? {wr_a1, wr_a2, 12'h000} : {wr_a1, wr_a2, wr_b};
    assign next_beat = beat_q + 3'd1;

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        wait_cnt_d = wait_cnt_q;
        result_d   = result_q;
        timeout_d  = timeout_q;
        // Bus returns to zero whenever no beat is being driven.
        lp_valid_d = 1'b0;
        lp_a1_d    = '0;
        lp_a2_d    = '0;
        lp_b_d     = '0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d                     = StSend;
                    beat_d                      = 3'd0;
                    lp_valid_d                  = 1'b1;
                    {lp_a1_d, lp_a2_d, lp_b_d}  = rows_q[0];
                end
            end
            StSend: begin
                if (beat_q == LastBeat) begin
                    state_d    = StWait;
                    wait_cnt_d = '0;
                end else begin
                    beat_d                      = next_beat;
                    lp_valid_d                  = 1'b1;
                    {lp_a1_d, lp_a2_d, lp_b_d}  = rows_q[next_beat];
                end
            end
            StWait: begin
                // A real answer wins over a coincident timeout expiry.
                if (lp.lp_out_valid) begin
                    result_d  = lp.lp_out_max_value;
                    timeout_d = 1'b0;
                    state_d   = StDone;
                end else if (wait_cnt_q == WaitLast) begin
                    result_d  = 12'h800;
                    timeout_d = 1'b1;
                    state_d   = StDone;
                end else begin
                    wait_cnt_d = wait_cnt_q + 24'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            beat_q     <= '0;
            wait_cnt_q <= '0;
            lp_valid_q <= 1'b0;
            lp_a1_q    <= '0;
            lp_a2_q    <= '0;
            lp_b_q     <= '0;
            result_q   <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            wait_cnt_q <= wait_cnt_d;
            lp_valid_q <= lp_valid_d;
            lp_a1_q    <= lp_a1_d;
            lp_a2_q    <= lp_a2_d;
            lp_b_q     <= lp_b_d;
            result_q   <= result_d;
            timeout_q  <= timeout_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 7; i++) begin
                rows_q[i] <= '0;
            end
        end else if (row_we) begin
            rows_q[wr_addr] <= row_wdata;
        end
    end

    assign lp.lp_valid = lp_valid_q;
    assign lp.lp_a1    = lp_a1_q;
    assign lp.lp_a2    = lp_a2_q;
    assign lp.lp_b     = lp_b_q;

    assign busy    = (state_q == StSend) || (state_q == StWait);
    assign done    = (state_q == StDone);
    assign result  = result_q;
    assign timeout = timeout_q;

endmodule
